// File: rtl/muxnway_rr_if.sv
// rtl/muxnway_rr_if.sv - handshake bundle between producers, muxnway_rr and its consumer
//
// Groups the datapath and handshake signals of muxnway_rr.
//   in_data   N*WIDTH  flattened producer data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  N        per-channel valid
//   in_ready  N        per-channel ready (one-hot or zero)
//   mode      1        0 = fixed select, 1 = round-robin
//   sel       SELW     channel chosen in fixed mode
//   out_data  WIDTH    registered output data
//   out_chan  SELW     channel id of the held beat
//   out_valid 1        output register holds a beat
//   out_ready 1        consumer accepts the beat
// Modports: master = producers/consumer side, slave = the mux.
interface muxnway_rr_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/muxnway_rr.sv
// rtl/muxnway_rr.sv - N-way registered mux with fixed-select and round-robin arbitration
//
// Selects one of N valid/ready input channels into a one-entry output register.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   bus         muxnway_rr_if.slave (inputs, output beat, handshakes, mode, sel)
//   xfer_count  16-bit count of output transfers, wraps (only with MUXNWAY_COUNT_EN)
// Optional feature macro: MUXNWAY_COUNT_EN adds the xfer_count port and counter.
module muxnway_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  muxnway_rr_if.slave  bus
`ifdef MUXNWAY_COUNT_EN
  ,
  output logic [15:0]  xfer_count
`endif
);

  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  chan_q;
  logic             valid_q;
  logic [SELW-1:0]  last;

  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] grant_data;
  logic             accept;
  logic             in_xfer;
  logic             out_xfer;

  assign accept   = !valid_q || bus.out_ready;
  assign in_xfer  = grant_vld && accept;
  assign out_xfer = valid_q && bus.out_ready;

  // Grant selection. Fixed mode matches sel against real channel numbers only,
  // so a sel beyond N-1 simply never grants. Round-robin scans last+1 .. last+N
  // modulo N and keeps the first valid hit.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (!bus.mode) begin
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          grant     = SELW'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = SELW'((int'(last) + k) % N);
        if (!grant_vld && bus.in_valid[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the granted channel and only when the slot is free;
  // forced low during reset since the register is being cleared.
  always_comb begin
    bus.in_ready = '0;
    if (!rst && grant_vld) begin
      bus.in_ready[grant] = accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      last    <= SELW'(N - 1);
    end else begin
      if (in_xfer) begin
        data_q  <= grant_data;
        chan_q  <= grant;
        valid_q <= 1'b1;
        if (bus.mode) begin
          last <= grant;
        end
      end else if (out_xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

`ifdef MUXNWAY_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= 16'd0;
    end else if (out_xfer) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/muxnway_rr.md
# muxnway_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. It is the successor to the combinational 4-way 16-bit mux. It adds a one-entry output register, a fixed-select mode driven by `sel`, and a round-robin arbitration mode. It sits between multiple producers and a single consumer in the datapath.

## Interface
- `WIDTH`, 16, data width per channel
- `N`, 4, number of input channels (2..16)
- `SELW`, `$clog2(N)`, width of select and channel-id fields
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready, one-hot or zero
- `mode`  in  1  0 = fixed select, 1 = round-robin
- `sel`  in  SELW  channel chosen in fixed mode
- `out_data`  out  WIDTH  registered output data
- `out_chan`  out  SELW  channel id of the beat held in `out_data`
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  consumer accepts the beat

## Operation
- Reset is asynchronous and active-high.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_chan`=0.
  - Round-robin pointer `last`=N-1.
  - `in_ready` is all-zero while `rst` is high.
- `accept` = !`out_valid` || `out_ready`. The output slot is free this cycle.
- Grant selection (combinational):
  - mode 0: the grant is `sel` if `sel`<N and `in_valid[sel]`; otherwise there is no grant.
  - mode 1: the grant is the first i with `in_valid[i]`, searching from `last`+1 upward and wrapping modulo N; if no input is valid there is no grant.
- `in_ready[g]` = `accept` for the granted channel g. All other `in_ready` bits are 0. `in_ready` never depends on `in_valid` of any other channel in fixed mode.
- An input transfer occurs when `in_valid[g]` && `in_ready[g]`. At that clock edge:
  - `out_data` ← channel g data
  - `out_chan` ← g
  - `out_valid` ← 1
  - In mode 1 only, `last` ← g.
- An output transfer occurs when `out_valid` && `out_ready`. If there is no simultaneous input transfer, `out_valid` ← 0. `out_data` and `out_chan` hold their values.
- With `out_valid`=1 and `out_ready`=0:
  - The output register is frozen.
  - All `in_ready` bits are 0.
- `last` is unchanged in mode 0 and on cycles without an input transfer.
- `mode` and `sel` are sampled each cycle. A change takes effect on the same cycle's grant and never corrupts a beat already held.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 beat per cycle when `out_ready` is held high. A simultaneous output and input transfer replaces the held beat with no bubble.
- Round-robin fairness: with all N inputs continuously valid and `out_ready`=1, the grants are 0,1,…,N-1,0,… with no channel skipped.
- Boundary conditions:
  - `sel`≥N (N not a power of two): no grant.
  - `rst` asserted mid-transfer: the held beat is dropped and all state returns to its reset values immediately, without waiting for a clock edge.
  - First grant after reset in mode 1 is the lowest-numbered valid channel starting from 0.
- No combinational path from `in_valid` to `out_valid` or `out_data`. The only combinational input-to-output paths are `out_ready` to `in_ready` and `in_valid`/`mode`/`sel` to `in_ready`.

## Configuration
- `MUXNWAY_COUNT_EN` defined:
  - Adds output port `xfer_count`  out  16, counting completed output transfers.
  - Reset value 0; increments by 1 on each output transfer.
  - Wraps from 65535 to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
Parameters for all scenarios: WIDTH=16, N=4; channel i data = 16'h00A0+i unless stated.

1. **Reset values.** Assert `rst` with all inputs valid → `out_valid`=0, `out_data`=0, `in_ready`=4'b0000. Deassert `rst`, mode=1, `out_ready`=1 → the first beat out has `out_chan`=0, `out_data`=16'h00A0, one cycle after the transfer.
2. **Fixed mode.** mode=0, sel=2, `in_valid`=4'b1111, `out_ready`=1 → `in_ready`=4'b0100 every cycle; `out_data`=16'h00A2 and `out_chan`=2 on every beat.
3. **Round-robin.** mode=1, `in_valid`=4'b1111, `out_ready`=1 for 8 cycles → `out_chan` sequence 0,1,2,3,0,1,2,3. Repeat with `in_valid`=4'b1010 → sequence 1,3,1,3.
4. **Backpressure.** Hold `out_ready`=0 after one beat (channel 1, 16'h00A1) → `out_valid` stays 1, the data stays 16'h00A1, `in_ready`=0 for 5 cycles. Release `out_ready` → the next beat, from channel 2, appears the following cycle.
5. **Reset mid-operation.** Assert `rst` asynchronously between clock edges while `out_valid`=1 → `out_valid` drops to 0 immediately. After release, round-robin restarts from channel 0.
6. **Counter (with `MUXNWAY_COUNT_EN`).** 70000 back-to-back output transfers → `xfer_count`=70000−65536=4464. Without the macro, the port is absent and the bench compiles with the port excluded.
